cmd_dispatcher: RTL



---
 rtl/cmd_pkg.sv | 21 ++
 rtl/cmd_fifo.sv | 52 +++++
 rtl/cmd_dispatcher.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared constants for the command dispatcher: opcodes, command field
// positions and FSM state encodings.
package cmd_pkg;

  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_FENCE = 8'hFF;

  localparam int OPC_HI  = 63;
  localparam int OPC_LO  = 56;
  localparam int SLOT_HI = 55;
  localparam int SLOT_LO = 52;
  localparam int ENG_HI  = 51;
  localparam int ENG_LO  = 48;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_FENCE  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; head word is exposed combinationally so the
// dispatcher can decode it in the same cycle it decides to pop.
module cmd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Host command front end: buffers commands and issues one-cycle pulses to engines.
// Optional CMD_PERF_CNT_EN adds issue/stall/drop performance counters.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int CMD_W   = 64,
  parameter int DEPTH   = 8,
  parameter int NUM_ENG = 4,
  parameter int ADDR_W  = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_in_valid,
  output logic                   cmd_in_ready,
  input  logic [CMD_W-1:0]       cmd_in_data,
  output logic [NUM_ENG-1:0]     eng_valid,
  input  logic [NUM_ENG-1:0]     eng_ready,
  output logic [7:0]             eng_opcode,
  output logic [3:0]             eng_slot,
  output logic [ADDR_W-1:0]      eng_dma_addr,
  output logic                   halted,
  output logic                   err_bad_eng,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [1:0]             dbg_state
`ifdef CMD_PERF_CNT_EN
  ,
  output logic [31:0]            perf_issued,
  output logic [31:0]            perf_stall,
  output logic [15:0]            perf_dropped
`endif
);

  state_t             state_q, state_d;
  logic [NUM_ENG-1:0] eng_valid_q, eng_valid_d, busy_mask_q;
  logic [7:0]         opc_q;
  logic [3:0]         slot_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               halted_q, err_q, rdy_en_q;

  logic [CMD_W-1:0]   head;
  logic               full, empty, push, pop, issue, drop;
  logic [7:0]         head_opc;
  logic [3:0]         head_eng;
  logic               eng_ok, eng_avail;

  assign cmd_in_ready = rdy_en_q && !full && !halted_q;
  assign push         = cmd_in_valid && cmd_in_ready;

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cmd_in_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign head_opc = head[OPC_HI:OPC_LO];
  assign head_eng = head[ENG_HI:ENG_LO];
  assign eng_ok   = ({1'b0, head_eng} < 5'(NUM_ENG));

  // An engine pulsed this cycle still shows ready; busy_mask blocks a re-issue.
  always_comb begin
    eng_avail = 1'b0;
    for (int i = 0; i < NUM_ENG; i++)
      if (head_eng == 4'(i)) eng_avail = eng_ready[i] && !busy_mask_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (!empty && head_opc == OP_HALT)       state_d = S_HALTED;
        else if (!empty && head_opc == OP_FENCE) state_d = S_FENCE;
      end
      S_FENCE:  if (&eng_ready && busy_mask_q == '0) state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    issue = 1'b0;
    drop  = 1'b0;
    if (state_q == S_FETCH && !empty) begin
      if (head_opc == OP_HALT || head_opc == OP_FENCE) begin
        pop = 1'b1;
      end else if (!eng_ok) begin
        pop  = 1'b1;
        drop = 1'b1;
      end else if (eng_avail) begin
        pop   = 1'b1;
        issue = 1'b1;
      end
    end
    for (int i = 0; i < NUM_ENG; i++)
      eng_valid_d[i] = issue && (head_eng == 4'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_valid_q <= '0;
      busy_mask_q <= '0;
      opc_q       <= '0;
      slot_q      <= '0;
      addr_q      <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      eng_valid_q <= eng_valid_d;
      busy_mask_q <= eng_valid_d;
      rdy_en_q    <= 1'b1;
      if (issue) begin
        opc_q  <= head_opc;
        slot_q <= head[SLOT_HI:SLOT_LO];
        addr_q <= head[ADDR_W-1:0];
      end
      if (state_q == S_FETCH && state_d == S_HALTED) halted_q <= 1'b1;
      if (drop) err_q <= 1'b1;
    end
  end

  assign eng_valid    = eng_valid_q;
  assign eng_opcode   = opc_q;
  assign eng_slot     = slot_q;
  assign eng_dma_addr = addr_q;
  assign halted       = halted_q;
  assign err_bad_eng  = err_q;
  assign dbg_state    = state_q;

`ifdef CMD_PERF_CNT_EN
  logic [31:0] issued_q, stall_q;
  logic [15:0] dropped_q;
  logic        stall;

  assign stall = (state_q == S_FETCH) && !empty && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q  <= '0;
      stall_q   <= '0;
      dropped_q <= '0;
    end else if (!halted_q) begin
      if (issue && issued_q != '1)  issued_q  <= issued_q + 32'd1;
      if (stall && stall_q != '1)   stall_q   <= stall_q + 32'd1;
      if (drop && dropped_q != '1)  dropped_q <= dropped_q + 16'd1;
    end
  end

  assign perf_issued  = issued_q;
  assign perf_stall   = stall_q;
  assign perf_dropped = dropped_q;
`endif

endmodule
